// File: rtl/fifo_read_stream.sv
// Read-side FIFO consumer: pops words, absorbs the one-cycle RAM latency in a 2-entry buffer,
// and presents them as a valid/ready stream with burst-last tags. Optional RD_STREAM_STATS_EN adds o_word_cnt.
module fifo_read_stream #(
  parameter int RAM_WIDTH = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  input  logic                 r_empty,
  input  logic [RAM_WIDTH-1:0] r_data,
  output logic                 r_req,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [RAM_WIDTH-1:0] o_data,
  output logic                 o_last
`ifdef RD_STREAM_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] o_word_cnt
`endif
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  if (BURST_LEN < 1 || CNT_WIDTH < 1) begin : g_param_check
    $error("fifo_read_stream: BURST_LEN and CNT_WIDTH must be >= 1");
  end

  occ_t                 occ;
  occ_t                 occ_next;
  logic                 inflight;
  logic [BW-1:0]        burst_cnt;
  logic [RAM_WIDTH-1:0] buf1_data;
  logic                 buf1_last;

  logic pop;
  logic out_fire;
  logic is_last;
  logic wr_head;

  assign o_valid  = (occ != EMPTY);
  assign out_fire = o_valid & o_ready;
  assign pop      = r_req & ~r_empty;
  assign is_last  = (burst_cnt == BW'(BURST_LEN - 1));

  // Pop only when the word is guaranteed a slot: either spare room, or a slot frees up this cycle.
  assign r_req = ~r_rst & ((occ == EMPTY) | ((occ == ONE) & ~inflight) | out_fire);

  // The arriving word lands in the head slot when the buffer is (or is about to become) empty.
  assign wr_head = (occ == EMPTY) | ((occ == ONE) & out_fire);

  always_comb begin
    occ_next = occ;
    unique case (occ)
      EMPTY:   occ_next = inflight ? ONE : EMPTY;
      ONE:     occ_next = (inflight == out_fire) ? ONE : (inflight ? TWO : EMPTY);
      TWO:     occ_next = out_fire ? (inflight ? TWO : ONE) : TWO;
      default: occ_next = EMPTY;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every read in this block sees pre-edge values.
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      occ       <= EMPTY;
      inflight  <= 1'b0;
      burst_cnt <= '0;
      // NOTE: the buffer slots are reset because the head slot drives o_data/o_last directly.
      o_data    <= '0;
      o_last    <= 1'b0;
      buf1_data <= '0;
      buf1_last <= 1'b0;
    end else begin
      inflight <= pop;
      occ      <= occ_next;

      if (out_fire) begin
        o_data <= buf1_data;
        o_last <= buf1_last;
      end

      // Capture happens exactly one cycle after the pop; the tag is fixed here.
      if (inflight) begin
        burst_cnt <= is_last ? '0 : burst_cnt + 1'b1;
        if (wr_head) begin
          o_data <= r_data;
          o_last <= is_last;
        end else begin
          buf1_data <= r_data;
          buf1_last <= is_last;
        end
      end
    end
  end

`ifdef RD_STREAM_STATS_EN
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      o_word_cnt <= '0;
    end else if (out_fire) begin
      o_word_cnt <= o_word_cnt + 1'b1;
    end
  end
`endif

  a_no_overflow: assert property (@(posedge r_clk) disable iff (r_rst) !((occ == TWO) && inflight));

endmodule

// File: tb/tb_fifo_read_stream.sv
// Directed bench for fifo_read_stream: a queue models the FIFO read port (data one cycle after pop)
// and each step checks the stream outputs against hand-derived values.
module tb_fifo_read_stream;

  localparam int W   = 8;
  localparam int BL  = 4;
  localparam int CW  = 16;

  logic         r_clk;
  logic         r_rst;
  logic         r_empty;
  logic [W-1:0] r_data;
  logic         r_req;
  logic         o_valid;
  logic         o_ready;
  logic [W-1:0] o_data;
  logic         o_last;
`ifdef RD_STREAM_STATS_EN
  logic [CW-1:0] o_word_cnt;
`endif

  fifo_read_stream #(.RAM_WIDTH(W), .BURST_LEN(BL), .CNT_WIDTH(CW)) dut (
    .r_clk   (r_clk),
    .r_rst   (r_rst),
    .r_empty (r_empty),
    .r_data  (r_data),
    .r_req   (r_req),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_last  (o_last)
`ifdef RD_STREAM_STATS_EN
    ,
    .o_word_cnt (o_word_cnt)
`endif
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  logic [W-1:0] fifo_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [W-1:0] v);
    fifo_q.push_back(v);
    r_empty = 1'b0;
  endtask

  // One clock: let combinational r_req settle, sample the pop, then present popped data after the edge.
  task automatic tick();
    bit p;
    #1;
    p = r_req & ~r_empty;
    @(posedge r_clk);
    #1;
    if (p) r_data = fifo_q.pop_front();
    r_empty = (fifo_q.size() == 0);
  endtask

  task automatic do_reset();
    r_rst   = 1'b1;
    o_ready = 1'b0;
    fifo_q.delete();
    r_empty = 1'b1;
    tick();
    r_rst = 1'b0;
  endtask

  // Drain n words expected as first, first+1, ...; mode 0 = ready always high (no gaps allowed),
  // mode 1 = ready toggles each cycle (hold rule checked while stalled).
  task automatic run_stream(input string tag, input int first, input int n, input int mode);
    int k = 0;
    int last_cyc = -1;
    bit hold_pend = 1'b0;
    logic [W-1:0] held = '0;
    for (int cyc = 0; cyc < 200 && k < n; cyc++) begin
      o_ready = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
      if (hold_pend && o_valid) check({tag, "_hold"}, o_data, held);
      hold_pend = 1'b0;
      if (o_valid && o_ready) begin
        check({tag, "_data"}, o_data, first + k);
        check({tag, "_last"}, o_last, (k % BL) == BL - 1);
        if (mode == 0 && k > 0) check({tag, "_gap"}, cyc - last_cyc, 1);
        last_cyc = cyc;
        k++;
      end else if (o_valid) begin
        held = o_data;
        hold_pend = 1'b1;
      end
      tick();
    end
    check({tag, "_count"}, k, n);
    o_ready = 1'b0;
  endtask

  initial begin
    // 1: reset with an empty FIFO
    r_rst   = 1'b1;
    r_empty = 1'b1;
    r_data  = '0;
    o_ready = 1'b0;
    #1;
    check("t1_req_in_reset", r_req, 0);
    tick();
    tick();
    check("t1_req_in_reset2", r_req, 0);
    check("t1_valid", o_valid, 0);
    check("t1_data", o_data, 0);
    check("t1_last", o_last, 0);
`ifdef RD_STREAM_STATS_EN
    check("t1_word_cnt", o_word_cnt, 0);
`endif
    r_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_valid_idle", o_valid, 0);
    end

    // 2: single word, two-cycle latency from pop to o_valid
    push(8'hA5);
    #1;
    check("t2_req", r_req, 1);
    tick();
    check("t2_valid_early", o_valid, 0);
    tick();
    check("t2_valid", o_valid, 1);
    check("t2_data", o_data, 8'hA5);
    check("t2_last", o_last, 0);
    o_ready = 1'b1;
    tick();
    check("t2_drained", o_valid, 0);
    o_ready = 1'b0;

    // 3: 8 words at full rate, bursts of 4
    do_reset();
    for (int i = 0; i < 8; i++) push(W'(i));
    run_stream("t3", 0, 8, 0);
    check("t3_drained", o_valid, 0);
`ifdef RD_STREAM_STATS_EN
    check("t3_word_cnt", o_word_cnt, 8);
`endif

    // 4: backpressure stops popping at two words, then a gapless drain
    do_reset();
    for (int i = 0; i < 5; i++) push(W'(i));
    tick();
    tick();
    #1;
    check("t4_req_low", r_req, 0);
    tick();
    tick();
    tick();
    check("t4_valid", o_valid, 1);
    check("t4_hold_data", o_data, 0);
    check("t4_pops", fifo_q.size(), 3);
    run_stream("t4", 0, 5, 0);

    // 5: toggling ready, 12 words, three bursts
    do_reset();
    for (int i = 0; i < 12; i++) push(W'(8'h20 + i));
    run_stream("t5", 8'h20, 12, 1);
`ifdef RD_STREAM_STATS_EN
    check("t5_word_cnt", o_word_cnt, 12);
`endif

    // 6: reset while one word is buffered and one is in flight; both are lost
    do_reset();
    for (int i = 10; i < 16; i++) push(W'(i));
    tick();
    tick();
    r_rst = 1'b1;
    tick();
    r_rst = 1'b0;
    check("t6_valid", o_valid, 0);
    check("t6_fifo_left", fifo_q.size(), 4);
`ifdef RD_STREAM_STATS_EN
    check("t6_word_cnt", o_word_cnt, 0);
`endif
    run_stream("t6", 12, 4, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
